// File: rtl/pitch_ball_datapath.sv
// pitch_ball_datapath: ball index, pitch-speed select, sprite draw/erase sweep and inter-frame wait timer.
// Build macro CURVE_BALL_EN makes the ball drop 1 px every two ball indices.
module pitch_ball_datapath #(
    parameter int unsigned BALL_SIZE   = 32'd4,
    parameter logic [7:0]  X_START     = 8'd150,
    parameter logic [6:0]  Y_START     = 7'd60,
    parameter logic [7:0]  X_STEP      = 8'd12,
    parameter int unsigned WAIT_SLOW   = 32'd12_500_000,
    parameter int unsigned WAIT_MED    = 32'd8_000_000,
    parameter int unsigned WAIT_FAST   = 32'd5_000_000,
    parameter logic [2:0]  BALL_COLOUR = 3'b111,
    parameter logic [2:0]  BG_COLOUR   = 3'b010,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rate,
    input  logic       plot,
    input  logic       countenable,
    input  logic       wait_countenable,
    input  logic       erase,
    input  logic       update,
    output logic       got_rate,
    output logic       done_draw,
    output logic       done_wait,
    output logic       done_erase,
    output logic       done_update,
    output logic [3:0] ball,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       writeEn
);

    localparam int unsigned PIX_N  = BALL_SIZE * BALL_SIZE;
    localparam int unsigned CNT_W  = $clog2(PIX_N);
    localparam int unsigned WAIT_W = 32'd24;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIX_N - 32'd1);
    localparam logic [3:0] BALL_MAX = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RATE  = 3'd1,
        S_SWEEP = 3'd2,
        S_WAIT  = 3'd3,
        S_UPD   = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_NONE   = 3'd0,
        C_RATE   = 3'd1,
        C_DRAW   = 3'd2,
        C_ERASE  = 3'd3,
        C_UPDATE = 3'd4,
        C_WAIT   = 3'd5
    } cmd_t;

    function automatic logic lfsr_fb(input logic [15:0] v);
        return v[15] ^ v[13] ^ v[12] ^ v[10];
    endfunction

    function automatic logic [WAIT_W-1:0] speed_sel(input logic [1:0] tap);
        logic [WAIT_W-1:0] s;
        case (tap)
            2'b00:   s = WAIT_W'(WAIT_SLOW);
            2'b10:   s = WAIT_W'(WAIT_FAST);
            default: s = WAIT_W'(WAIT_MED);
        endcase
        return s;
    endfunction

    function automatic logic [7:0] pix_dx(input logic [CNT_W-1:0] c);
        return 8'(32'(c) % BALL_SIZE);
    endfunction

    function automatic logic [6:0] pix_dy(input logic [CNT_W-1:0] c);
        return 7'(32'(c) / BALL_SIZE);
    endfunction

    state_t            state_r, state_next_s;
    cmd_t              cmd_r, cmd_next_s;
    logic              req_s;
    logic              hold_next_s;
    logic [15:0]       lfsr_r;
    logic [WAIT_W-1:0] speed_r, speed_next_s;
    logic [WAIT_W-1:0] wcnt_r, wcnt_next_s;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s, cnt_inc_s;
    logic [3:0]        ball_r, ball_next_s;
    logic [7:0]        bx_s, x_r, x_next_s;
    logic [6:0]        by_s, y_r, y_next_s;
    logic [2:0]        colour_r, colour_next_s;
    logic              we_r, we_next_s;
    logic              got_rate_r, done_draw_r, done_wait_r, done_erase_r, done_update_r;

    assign cnt_inc_s = cnt_r + CNT_W'(1);
    assign bx_s      = X_START - (8'(ball_r) * X_STEP);
`ifdef CURVE_BALL_EN
    assign by_s      = Y_START + {4'b0000, ball_r[3:1]};
`else
    assign by_s      = Y_START;
`endif

    // Speed LFSR free-runs every cycle so the pitch speed depends on when rate arrives.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_fb(lfsr_r)};
        end
    end

    // Request line that keeps the currently held done/got flag alive.
    always_comb begin
        case (cmd_r)
            C_RATE:   req_s = rate;
            C_DRAW:   req_s = plot & countenable;
            C_ERASE:  req_s = erase;
            C_UPDATE: req_s = update;
            C_WAIT:   req_s = wait_countenable;
            default:  req_s = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= S_IDLE;
            cmd_r   <= C_NONE;
        end else begin
            state_r <= state_next_s;
            cmd_r   <= cmd_next_s;
        end
    end

    // Next-state logic; IDLE arbitrates simultaneous strobes by fixed priority.
    always_comb begin
        state_next_s = state_r;
        cmd_next_s   = cmd_r;
        case (state_r)
            S_IDLE: begin
                if (rate) begin
                    state_next_s = S_RATE;
                    cmd_next_s   = C_RATE;
                end else if (plot && countenable) begin
                    state_next_s = S_SWEEP;
                    cmd_next_s   = C_DRAW;
                end else if (erase) begin
                    state_next_s = S_SWEEP;
                    cmd_next_s   = C_ERASE;
                end else if (update) begin
                    state_next_s = S_UPD;
                    cmd_next_s   = C_UPDATE;
                end else if (wait_countenable) begin
                    state_next_s = S_WAIT;
                    cmd_next_s   = C_WAIT;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RATE, S_UPD, S_HOLD: begin
                state_next_s = req_s ? S_HOLD : S_IDLE;
            end
            S_SWEEP: begin
                state_next_s = (cnt_r == CNT_LAST) ? S_HOLD : S_SWEEP;
            end
            S_WAIT: begin
                if (!wait_countenable) begin
                    state_next_s = S_IDLE;
                end else if (wcnt_r <= 24'd1) begin
                    state_next_s = S_HOLD;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Output/datapath next values; VGA outputs present the pixel the counter will point at.
    always_comb begin
        ball_next_s   = ball_r;
        cnt_next_s    = cnt_r;
        wcnt_next_s   = wcnt_r;
        speed_next_s  = speed_r;
        x_next_s      = x_r;
        y_next_s      = y_r;
        colour_next_s = colour_r;
        we_next_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                case (state_next_s)
                    S_RATE: begin
                        speed_next_s = speed_sel(lfsr_r[1:0]);
                        ball_next_s  = 4'd0;
                    end
                    S_SWEEP: begin
                        cnt_next_s    = {CNT_W{1'b0}};
                        we_next_s     = 1'b1;
                        x_next_s      = bx_s;
                        y_next_s      = by_s;
                        colour_next_s = (cmd_next_s == C_DRAW) ? BALL_COLOUR : BG_COLOUR;
                    end
                    S_UPD:   ball_next_s = (ball_r == BALL_MAX) ? BALL_MAX : ball_r + 4'd1;
                    S_WAIT:  wcnt_next_s = speed_r;
                    default: ball_next_s = ball_r;
                endcase
            end
            S_SWEEP: begin
                if (state_next_s == S_SWEEP) begin
                    cnt_next_s = cnt_inc_s;
                    we_next_s  = 1'b1;
                    x_next_s   = bx_s + pix_dx(cnt_inc_s);
                    y_next_s   = by_s + pix_dy(cnt_inc_s);
                end else begin
                    cnt_next_s = {CNT_W{1'b0}};
                end
            end
            S_WAIT: begin
                if (state_next_s == S_WAIT) begin
                    wcnt_next_s = wcnt_r - 24'd1;
                end else begin
                    wcnt_next_s = {WAIT_W{1'b0}};
                end
            end
            default: we_next_s = 1'b0;
        endcase
    end

    assign hold_next_s = (state_next_s == S_RATE) || (state_next_s == S_UPD) ||
                         (state_next_s == S_HOLD);

    // Datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            ball_r        <= 4'd0;
            cnt_r         <= {CNT_W{1'b0}};
            wcnt_r        <= {WAIT_W{1'b0}};
            speed_r       <= WAIT_W'(WAIT_MED);
            x_r           <= 8'd0;
            y_r           <= 7'd0;
            colour_r      <= 3'd0;
            we_r          <= 1'b0;
            got_rate_r    <= 1'b0;
            done_draw_r   <= 1'b0;
            done_wait_r   <= 1'b0;
            done_erase_r  <= 1'b0;
            done_update_r <= 1'b0;
        end else begin
            ball_r        <= ball_next_s;
            cnt_r         <= cnt_next_s;
            wcnt_r        <= wcnt_next_s;
            speed_r       <= speed_next_s;
            x_r           <= x_next_s;
            y_r           <= y_next_s;
            colour_r      <= colour_next_s;
            we_r          <= we_next_s;
            got_rate_r    <= hold_next_s && (cmd_next_s == C_RATE);
            done_draw_r   <= hold_next_s && (cmd_next_s == C_DRAW);
            done_wait_r   <= hold_next_s && (cmd_next_s == C_WAIT);
            done_erase_r  <= hold_next_s && (cmd_next_s == C_ERASE);
            done_update_r <= hold_next_s && (cmd_next_s == C_UPDATE);
        end
    end

    assign got_rate    = got_rate_r;
    assign done_draw   = done_draw_r;
    assign done_wait   = done_wait_r;
    assign done_erase  = done_erase_r;
    assign done_update = done_update_r;
    assign ball        = ball_r;
    assign x           = x_r;
    assign y           = y_r;
    assign colour      = colour_r;
    assign writeEn     = we_r;

endmodule

// File: doc/pitch_ball_datapath.md
Name: pitch_ball_datapath

Overview:
- Datapath stage directly downstream of the game control FSM. Consumes the ball-phase command strobes (rate, plot/countenable, wait_countenable, erase, update) and returns their completion flags (got_rate, done_draw, done_wait, done_erase, done_update) plus the current ball index.
- Owns the pitched ball: position, pitch-speed selection, the pixel sweep that draws or erases the ball sprite, and the inter-frame wait timer.
- Drives the VGA adapter write port (x, y, colour, writeEn) during ball draw and erase.

Parameters:
- BALL_SIZE, 4, side length of the square ball sprite in pixels (2..4).
- X_START, 150, x of ball index 0 (pitcher's hand).
- Y_START, 60, y of ball index 0.
- X_STEP, 12, leftward x step per ball index.
- WAIT_SLOW, 12_500_000, wait cycles for a slow pitch.
- WAIT_MED, 8_000_000, wait cycles for a medium pitch.
- WAIT_FAST, 5_000_000, wait cycles for a fast pitch.
- BALL_COLOUR, 3'b111, sprite colour.
- BG_COLOUR, 3'b010, colour used for erase (field green).
- LFSR_SEED, 16'hACE1, non-zero reset value of the speed LFSR.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rate  in  1  select pitch speed; restart pitch at ball 0.
- plot  in  1  draw ball request.
- countenable  in  1  pixel-counter enable; qualifies plot.
- wait_countenable  in  1  run the wait timer.
- erase  in  1  erase ball request.
- update  in  1  advance ball index.
- got_rate  out  1  rate latched.
- done_draw  out  1  sprite fully written.
- done_wait  out  1  wait period expired.
- done_erase  out  1  sprite fully erased.
- done_update  out  1  ball index advanced.
- ball  out  4  current ball index, 0..11.
- x  out  8  VGA x.
- y  out  7  VGA y.
- colour  out  3  VGA colour.
- writeEn  out  1  VGA write strobe.

Behaviour:
- Reset, applied at the clock edge: ball=0, all done flags and got_rate=0, writeEn=0, x=y=colour=0, pixel counter=0, wait counter=0, LFSR=LFSR_SEED, speed register=WAIT_MED.
- Reset mid-draw or mid-erase aborts the sweep. No further writeEn pulses occur.
- The 16-bit Fibonacci LFSR (taps 16,14,13,11) shifts every cycle regardless of commands.
- Internal FSM states: IDLE, RATE, SWEEP, WAIT, UPD, HOLD.
- Command priority when several strobes are high: rate > plot&countenable > erase > update > wait_countenable.

rate:
- On the first cycle rate is high in IDLE, latch the speed from LFSR[1:0]: 00→WAIT_SLOW, 01/11→WAIT_MED, 10→WAIT_FAST.
- Set ball=0.
- got_rate rises the next cycle.

plot&countenable and erase:
- A pixel counter sweeps 0..BALL_SIZE²-1, one pixel per cycle, row-major.
- x = bx + cnt%BALL_SIZE and y = by + cnt/BALL_SIZE, with writeEn=1 for each pixel.
- Colour is BALL_COLOUR for plot and BG_COLOUR for erase.
- Latency: first write 1 cycle after the request. The done flag rises the cycle after the last pixel write, so done comes BALL_SIZE²+1 cycles after the request.
- Base position: bx = X_START − ball·X_STEP (8-bit), by = Y_START.

wait_countenable:
- Load the wait counter with the speed value on entry, then decrement once per cycle.
- done_wait rises when the counter reaches 0.
- If wait_countenable drops before expiry, the counter is abandoned and reloads on the next entry.

update:
- Advance ball to ball+1, saturating at 11.
- done_update rises the next cycle, at which point the new ball value is already visible.
- Update at 11 leaves ball at 11 and still completes.

Done-flag handshake (HOLD):
- Each done/got flag stays high while its request stays high.
- The flag clears, and the FSM returns to IDLE, in the first cycle the request is low.
- writeEn=0 in every state except SWEEP.

Optional Feature:
- Macro: CURVE_BALL_EN.
- Defined: by = Y_START + ball[3:1], so the ball drops 1 px every two indices. Maximum y is Y_START+5.
- Undefined: by = Y_START constant.
- All other timing is identical in both builds.

Test Plan:
- Reset: hold reset 2 cycles → ball=0, writeEn=0, all done flags 0, LFSR=16'hACE1.
- rate pulse high 3 cycles with the LFSR forced to ..10 → got_rate=1 on cycles 2–3, speed=WAIT_FAST, ball=0; got_rate=0 the cycle after rate falls.
- plot+countenable held, ball=0, defaults → 16 writes at x 150..153, y 60..63, colour 3'b111; done_draw on cycle 18; clears 1 cycle after plot falls.
- wait_countenable held, with WAIT_FAST overridden to 10 → done_wait exactly 11 cycles after assertion. A second run, with wait dropped at cycle 5 and re-asserted, takes the full 11 cycles.
- 12 update handshakes → ball goes 1..11 then stays 11. erase at ball=11 writes x 18..21 with colour 3'b010. With CURVE_BALL_EN, y is 65..68.
- reset asserted at pixel 7 of a draw → writeEn=0 the next cycle, and done_draw is never asserted.
